// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter for the MIPS data-memory port.
// Stores to TXDATA queue bytes in a small FIFO; a four-state FSM serialises them LSB first.
module mmio_uart_tx #(
    parameter int          DEPTH        = 4,
    parameter int          CLKS_PER_BIT = 16,
    parameter logic [31:0] BASE_ADDR    = 32'hFFFF_FF00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dmem_write,
    input  logic [31:0] alu_out,
    input  logic [31:0] dmem_write_data,
    output logic        io_sel,
    output logic [31:0] io_read_data,
    output logic        tx
);

    localparam int PTR_W  = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [1:0] OFF_TXDATA = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_COUNT  = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Address decode and register-write strobes
    // ------------------------------------------------------------------
    logic [1:0] offset;
    logic       reg_wr;
    logic       push_req;
    logic       push;
    logic       pop;
    logic       ovf_clr;
    logic       unused_bits;

    assign io_sel   = (alu_out[31:4] == BASE_ADDR[31:4]);
    assign offset   = alu_out[3:2];
    assign reg_wr   = io_sel & dmem_write & ~reset;
    assign push_req = reg_wr & (offset == OFF_TXDATA);
    assign ovf_clr  = reg_wr & (offset == OFF_STATUS) & dmem_write_data[3];

    assign unused_bits = ^{alu_out[1:0], dmem_write_data[31:8]};

    // ------------------------------------------------------------------
    // FIFO: per-entry byte registers, circular pointers, occupancy count
    // ------------------------------------------------------------------
    logic [7:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             fifo_empty;
    logic             fifo_full;
    logic [7:0]       fifo_head;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_W'(DEPTH));
    assign fifo_head  = mem_q[rd_ptr_q];

    // Full is judged on pre-edge state, so a pop on this edge never rescues a push.
    assign push = push_req & ~fifo_full;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_fifo_entry
            always_ff @(posedge clk) begin
                if (push && (wr_ptr_q == PTR_W'(gi))) begin
                    mem_q[gi] <= dmem_write_data[7:0];
                end
            end
        end
    endgenerate

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        // Clear first so a same-edge set takes priority.
        if (ovf_clr) begin
            overflow_d = 1'b0;
        end
        if (push_req && fifo_full) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // ------------------------------------------------------------------
    // Transmit FSM: state register, next-state logic, output logic
    // ------------------------------------------------------------------
    state_t            state_q, state_d;
    logic [7:0]        shift_q, shift_d;
    logic [2:0]        bit_q, bit_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic              baud_done;
    logic              busy;

    assign baud_done = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
    assign pop       = (state_q == IDLE) & ~fifo_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            shift_q <= '0;
            bit_q   <= '0;
            baud_q  <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            baud_q  <= baud_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!fifo_empty) state_d = START;
            START:   if (baud_done) state_d = DATA;
            DATA:    if (baud_done && (bit_q == 3'd7)) state_d = STOP;
            STOP:    if (baud_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Shifter and counters advance alongside the state; the baud counter wraps on its terminal count.
    always_comb begin
        shift_d = shift_q;
        bit_d   = bit_q;
        baud_d  = baud_q;
        if (state_q == IDLE) begin
            if (pop) begin
                shift_d = fifo_head;
                bit_d   = '0;
                baud_d  = '0;
            end
        end else begin
            baud_d = baud_done ? '0 : baud_q + BAUD_W'(1);
            if ((state_q == DATA) && baud_done) begin
                shift_d = {1'b0, shift_q[7:1]};
                bit_d   = bit_q + 3'd1;
            end
        end
    end

    always_comb begin
        tx   = 1'b1;
        busy = 1'b1;
        case (state_q)
            IDLE:    busy = 1'b0;
            START:   tx   = 1'b0;
            DATA:    tx   = shift_q[0];
            default: tx   = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Combinational read port
    // ------------------------------------------------------------------
    logic [31:0] status_word;

    assign status_word = {28'd0, overflow_q, busy, fifo_full, fifo_empty};

    always_comb begin
        io_read_data = 32'd0;
        if (io_sel) begin
            case (offset)
                OFF_STATUS: io_read_data = status_word;
                OFF_COUNT:  io_read_data = {{(32 - CNT_W){1'b0}}, count_q};
                default:    io_read_data = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Randomized bench for mmio_uart_tx against a queue-and-timeline reference model.
// The model tracks queued bytes and the current frame as a cycle position within 10 bit times.
module tb_mmio_uart_tx;

    localparam int          DEPTH = 4;
    localparam int          CPB   = 4;
    localparam logic [31:0] BASE  = 32'hFFFF_FF00;

    logic        clk = 1'b0;
    logic        reset;
    logic        dmem_write;
    logic [31:0] alu_out;
    logic [31:0] dmem_write_data;
    logic        io_sel;
    logic [31:0] io_read_data;
    logic        tx;

    mmio_uart_tx #(
        .DEPTH        (DEPTH),
        .CLKS_PER_BIT (CPB),
        .BASE_ADDR    (BASE)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .dmem_write      (dmem_write),
        .alu_out         (alu_out),
        .dmem_write_data (dmem_write_data),
        .io_sel          (io_sel),
        .io_read_data    (io_read_data),
        .tx              (tx)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [7:0] m_q[$];
    logic       m_ovf  = 1'b0;
    logic       m_busy = 1'b0;
    int         m_pos  = 0;
    logic [7:0] m_byte = 8'h00;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic m_sel(input logic [31:0] addr);
        return addr[31:4] == BASE[31:4];
    endfunction

    function automatic logic [31:0] m_rdata(input logic [31:0] addr);
        logic [31:0] v;
        v = 32'd0;
        if (m_sel(addr)) begin
            if (addr[3:2] == 2'd1)
                v = {28'd0, m_ovf, m_busy, (m_q.size() == DEPTH), (m_q.size() == 0)};
            else if (addr[3:2] == 2'd2)
                v = 32'(m_q.size());
        end
        return v;
    endfunction

    // Serial level at the current point of the frame timeline.
    function automatic logic m_tx();
        int k;
        if (!m_busy) return 1'b1;
        k = m_pos / CPB;
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return m_byte[k-1];
    endfunction

    function automatic void model_edge(input logic rst, input logic we,
                                       input logic [31:0] addr, input logic [31:0] data);
        logic pre_full;
        if (rst) begin
            m_q.delete();
            m_ovf  = 1'b0;
            m_busy = 1'b0;
            m_pos  = 0;
            return;
        end
        pre_full = (m_q.size() == DEPTH);
        if (m_busy) begin
            m_pos++;
            if (m_pos == 10 * CPB) m_busy = 1'b0;
        end else if (m_q.size() != 0) begin
            m_byte = m_q.pop_front();
            m_busy = 1'b1;
            m_pos  = 0;
        end
        if (we && m_sel(addr) && addr[3:2] == 2'd1 && data[3]) m_ovf = 1'b0;
        if (we && m_sel(addr) && addr[3:2] == 2'd0) begin
            if (pre_full) m_ovf = 1'b1;
            else m_q.push_back(data[7:0]);
        end
    endfunction

    // One clock: drive at negedge, check read path, clock the model, check tx at next negedge.
    task automatic drive(input logic rst, input logic we,
                         input logic [31:0] addr, input logic [31:0] data);
        reset = rst;
        dmem_write = we;
        alu_out = addr;
        dmem_write_data = data;
        #1;
        check("io_sel", {31'd0, io_sel}, {31'd0, m_sel(addr)});
        check("io_read_data", io_read_data, m_rdata(addr));
        if (we) $display("store addr=%h data=%h rst=%0b qlen=%0d", addr, data, rst, m_q.size());
        @(posedge clk);
        model_edge(rst, we, addr, data);
        @(negedge clk);
        check("tx", {31'd0, tx}, {31'd0, m_tx()});
    endtask

    task automatic idle_cycle();
        drive(1'b0, 1'b0, ($urandom_range(0, 1) != 0) ? BASE + 32'h4 : BASE + 32'h8, 32'd0);
    endtask

    task automatic peek(input logic [31:0] addr, output logic [31:0] val);
        dmem_write = 1'b0;
        alu_out = addr;
        #1;
        val = io_read_data;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((m_busy || m_q.size() != 0) && n < 2000) begin
            idle_cycle();
            n++;
        end
        check("wait_idle_budget", (n < 2000) ? 32'd0 : 32'(n), 32'd0);
    endtask

    initial begin
        logic [31:0] v;
        int busy_cnt;
        int n;

        reset = 1'b1;
        dmem_write = 1'b0;
        alu_out = 32'd0;
        dmem_write_data = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset state
        check("rst_tx", {31'd0, tx}, 32'd1);
        peek(BASE + 32'h4, v);  check("rst_status", v, 32'h1);
        peek(BASE + 32'h8, v);  check("rst_count", v, 32'h0);
        peek(32'h0000_0040, v); check("rst_far_rdata", v, 32'h0);
        check("rst_far_sel", {31'd0, io_sel}, 32'd0);

        // Single byte frame
        drive(1'b0, 1'b1, BASE, 32'h55);
        busy_cnt = 0;
        for (int i = 0; i < 45; i++) begin
            drive(1'b0, 1'b0, BASE + 32'h4, 32'd0);
            peek(BASE + 32'h4, v);
            if (v[2]) busy_cnt++;
        end
        check("single_busy_cycles", 32'(busy_cnt), 32'd40);
        peek(BASE + 32'h4, v); check("single_status_end", v, 32'h1);

        // Overflow burst
        for (int i = 0; i < 6; i++) drive(1'b0, 1'b1, BASE, 32'hA0 + 32'(i));
        peek(BASE + 32'h4, v); check("ovf_status", v, 32'hE);
        peek(BASE + 32'h8, v); check("ovf_count", v, 32'd4);
        for (int i = 0; i < 10; i++) idle_cycle();
        drive(1'b0, 1'b1, BASE + 32'h4, 32'h8);
        peek(BASE + 32'h4, v); check("ovf_cleared", {28'd0, v[3:0]} & 32'h8, 32'h0);
        wait_idle();

        // Simultaneous push and pop
        drive(1'b0, 1'b1, BASE, 32'h3C);
        drive(1'b0, 1'b1, BASE, 32'hC3);
        peek(BASE + 32'h8, v); check("pushpop_count_a", v, 32'd1);
        n = 0;
        while (m_busy && n < 200) begin idle_cycle(); n++; end
        drive(1'b0, 1'b1, BASE, 32'h99);
        peek(BASE + 32'h8, v); check("pushpop_count_b", v, 32'd1);
        wait_idle();

        // Reset during DATA bit 3 with two bytes queued
        drive(1'b0, 1'b1, BASE, 32'h11);
        drive(1'b0, 1'b1, BASE, 32'h22);
        drive(1'b0, 1'b1, BASE, 32'h33);
        n = 0;
        while (!(m_busy && (m_pos / CPB) == 4) && n < 200) begin idle_cycle(); n++; end
        peek(BASE + 32'h8, v); check("midrst_queued", v, 32'd2);
        drive(1'b1, 1'b0, BASE + 32'h4, 32'd0);
        check("midrst_tx", {31'd0, tx}, 32'd1);
        peek(BASE + 32'h4, v); check("midrst_status", v, 32'h1);
        for (int i = 0; i < 60; i++) idle_cycle();

        // Address decode
        drive(1'b0, 1'b1, BASE + 32'h10, 32'h77);
        peek(BASE + 32'h8, v); check("decode_outside", v, 32'd0);
        drive(1'b0, 1'b1, BASE + 32'h3, 32'h5A);
        peek(BASE + 32'h8, v); check("decode_low_bits", v, 32'd1);
        wait_idle();

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            logic [31:0] addr;
            logic [31:0] data;
            logic        we;
            logic        rst;
            int          r;
            r = $urandom_range(0, 99);
            case ($urandom_range(0, 7))
                0, 1, 2: addr = BASE;
                3:       addr = BASE + 32'h4;
                4:       addr = BASE + 32'h8 + 32'($urandom_range(0, 3));
                5:       addr = BASE + 32'hC;
                6:       addr = BASE + 32'h3;
                default: addr = ($urandom_range(0, 1) != 0) ? BASE + 32'h10 : $urandom;
            endcase
            data = $urandom;
            we   = (r < 20);
            rst  = (r == 99) && ($urandom_range(0, 3) == 0);
            drive(rst, we, addr, data);
        end
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter on the single-cycle MIPS core's data-memory port, downstream of the core's store path.
- Decodes loads and stores in its 16-byte address window. Queues stored bytes in a small FIFO and serialises them 8N1 on one output pin.
- Read data is combinational, because the core expects load data in the same cycle as the address. The top level selects between dmem and this block with io_sel.

Parameters:
- DEPTH, 4: FIFO entries; power of two, minimum 2.
- CLKS_PER_BIT, 16: clock cycles per serial bit; minimum 2.
- BASE_ADDR, 32'hFFFF_FF00: window base; bits [3:0] must be 0.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high.
- dmem_write  input  1  core store strobe.
- alu_out  input  32  core data address.
- dmem_write_data  input  32  core store data.
- io_sel  output  1  alu_out[31:4] == BASE_ADDR[31:4]; combinational.
- io_read_data  output  32  load data; combinational; 0 when io_sel=0.
- tx  output  1  serial line; idles high.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high.
- alu_out[1:0] is ignored. Offsets are decoded on alu_out[3:2].
- Offset 0x0, TXDATA, write: push dmem_write_data[7:0] when io_sel & dmem_write & ~full. Reads return 0.
- Offset 0x4, STATUS, read: bit0 empty, bit1 full, bit2 busy (FSM != IDLE), bit3 overflow (sticky); other bits 0.
- Offset 0x4, STATUS, write: when data bit3=1, clear overflow. Other bits are ignored.
- Offset 0x8, COUNT, read: FIFO occupancy, zero-extended. Writes are ignored.
- Offset 0xC: reserved; reads 0, writes ignored.
- Push when full: byte dropped and overflow set. Full is evaluated on pre-edge state, so a same-cycle pop does not rescue the push.
- If a clear and a set of overflow land on the same edge, set wins.
- FIFO: circular buffer; read and write pointers wrap modulo DEPTH. A simultaneous push and pop when not full leaves the count unchanged.
- FSM states: IDLE, START, DATA, STOP.
- IDLE: tx=1. If FIFO non-empty, pop the head into the shift register, load bit counter 0 and baud counter 0, go to START.
- START: tx=0 for CLKS_PER_BIT cycles, then DATA.
- DATA: tx = shift[0], LSB first. Each bit is held CLKS_PER_BIT cycles, then shift right. After 8 bits, go to STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE.
- Frame is 10*CLKS_PER_BIT cycles from START entry to IDLE return. At least one IDLE cycle separates consecutive frames.
- Latency: a store sampled at edge N to an empty FIFO with FSM in IDLE is popped at edge N+1. tx is low from edge N+1.
- Baud counter counts 0..CLKS_PER_BIT-1 and wraps, giving a bit boundary on the terminal count.
- Reset values: FIFO empty, pointers 0, count 0, overflow 0, FSM IDLE, counters 0, tx=1.
- io_sel and io_read_data are combinational from inputs and registers.
- Reset mid-frame aborts the frame; tx=1 after that edge, and queued bytes are discarded.
- Stores sampled while reset=1 are ignored.
- Loads have no side effects; STATUS read does not clear overflow.

Test Plan:
- Run the bench with CLKS_PER_BIT=4, DEPTH=4.
- Reset: hold reset 2 cycles -> tx=1; STATUS reads 0x1; COUNT reads 0; io_sel=0 for alu_out=0x0000_0040 and io_read_data=0.
- Single byte: store 0x55 to 0xFFFF_FF00 -> tx=0 from next edge for 4 cycles, then 1,0,1,0,1,0,1,0 (4 cycles each), stop=1 for 4 cycles. busy=1 for 40 cycles, then STATUS=0x1.
- Overflow: store 0xA0..0xA5 on 6 consecutive cycles -> 0xA0 in shifter; COUNT=4 and full after 5th store; 0xA5 dropped; STATUS=0xE (full, busy, overflow).
- Overflow continued: frames then carry 0xA0..0xA4 in order with one idle cycle between frames. Store 0x8 to 0xFFFF_FF04 clears overflow.
- Simultaneous push/pop: FIFO holding 1 byte with FSM returning to IDLE; store on the pop cycle -> COUNT stays 1; no data loss.
- Reset mid-frame: assert reset during DATA bit 3 with 2 bytes queued -> tx=1 next edge; STATUS=0x1; no further frames.
- Address decode: a store to 0xFFFF_FF10 does not push; a store to 0xFFFF_FF03 does push (offset 0).
